// File: rtl/branch_rs.sv
// rtl/branch_rs.sv - in-order branch reservation station with CDB wakeup; BRANCH_RS_CDB_BYPASS_EN enables head issue straight from the CDB
// Only the head entry may issue, so branches resolve in program order.
module branch_rs #(
    parameter int ROB_DEPTH = 4,
    parameter int RS_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  logic [31:0]                  dispatch_instr,
    input  logic [31:0]                  dispatch_pc,
    input  logic [31:0]                  dispatch_imm,
    input  logic [$clog2(ROB_DEPTH)-1:0] dispatch_rob_tag,
    input  logic                         dispatch_rs1_ready,
    input  logic                         dispatch_rs2_ready,
    input  logic [31:0]                  dispatch_rs1_v,
    input  logic [31:0]                  dispatch_rs2_v,
    input  logic [$clog2(ROB_DEPTH)-1:0] dispatch_rs1_tag,
    input  logic [$clog2(ROB_DEPTH)-1:0] dispatch_rs2_tag,
    input  logic                         cdb_valid_in,
    input  logic [$clog2(ROB_DEPTH)-1:0] cdb_tag_in,
    input  logic [31:0]                  cdb_data_in,
    output logic                         comp_issue,
    output logic [31:0]                  rs1_v,
    output logic [31:0]                  rs2_v,
    output logic [31:0]                  pc,
    output logic [31:0]                  imm,
    output logic [31:0]                  instr,
    output logic [$clog2(ROB_DEPTH)-1:0] branch_tag
);
    localparam int TW = $clog2(ROB_DEPTH);
    localparam int PW = $clog2(RS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = (PW)'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(RS_DEPTH);

    logic [RS_DEPTH-1:0] valid_q, valid_d, rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [31:0]   instr_q [RS_DEPTH], instr_d [RS_DEPTH];
    logic [31:0]   pc_q [RS_DEPTH], pc_d [RS_DEPTH];
    logic [31:0]   imm_q [RS_DEPTH], imm_d [RS_DEPTH];
    logic [TW-1:0] rob_tag_q [RS_DEPTH], rob_tag_d [RS_DEPTH];
    logic [31:0]   rs1_v_q [RS_DEPTH], rs1_v_d [RS_DEPTH];
    logic [31:0]   rs2_v_q [RS_DEPTH], rs2_v_d [RS_DEPTH];
    logic [TW-1:0] rs1_tag_q [RS_DEPTH], rs1_tag_d [RS_DEPTH];
    logic [TW-1:0] rs2_tag_q [RS_DEPTH], rs2_tag_d [RS_DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic          comp_issue_q, comp_issue_d;
    logic [31:0]   iss_rs1_q, iss_rs1_d, iss_rs2_q, iss_rs2_d;
    logic [31:0]   iss_pc_q, iss_pc_d, iss_imm_q, iss_imm_d, iss_instr_q, iss_instr_d;
    logic [TW-1:0] iss_tag_q, iss_tag_d;

    logic          dispatch_fire, issue_fire, h1_rdy, h2_rdy;
    logic [31:0]   h1_v, h2_v;

    // Ready is taken from the registered count, so a full station never admits a dispatch even if it issues.
    assign dispatch_ready = (count_q < CNT_FULL);
    assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;

    always_comb begin
        valid_d   = valid_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rob_tag_d = rob_tag_q;
        rs1_v_d   = rs1_v_q;
        rs2_v_d   = rs2_v_q;
        rs1_tag_d = rs1_tag_q;
        rs2_tag_d = rs2_tag_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cdb_valid_in && valid_q[i]) begin
                if (!rs1_rdy_q[i] && rs1_tag_q[i] == cdb_tag_in) begin
                    rs1_rdy_d[i] = 1'b1;
                    rs1_v_d[i]   = cdb_data_in;
                end
                if (!rs2_rdy_q[i] && rs2_tag_q[i] == cdb_tag_in) begin
                    rs2_rdy_d[i] = 1'b1;
                    rs2_v_d[i]   = cdb_data_in;
                end
            end
        end

        h1_rdy = rs1_rdy_q[head_q];
        h1_v   = rs1_v_q[head_q];
        h2_rdy = rs2_rdy_q[head_q];
        h2_v   = rs2_v_q[head_q];
`ifdef BRANCH_RS_CDB_BYPASS_EN
        if (!h1_rdy && cdb_valid_in && rs1_tag_q[head_q] == cdb_tag_in) begin
            h1_rdy = 1'b1;
            h1_v   = cdb_data_in;
        end
        if (!h2_rdy && cdb_valid_in && rs2_tag_q[head_q] == cdb_tag_in) begin
            h2_rdy = 1'b1;
            h2_v   = cdb_data_in;
        end
`endif
        issue_fire = valid_q[head_q] && h1_rdy && h2_rdy && !flush;

        comp_issue_d = issue_fire;
        iss_rs1_d    = iss_rs1_q;
        iss_rs2_d    = iss_rs2_q;
        iss_pc_d     = iss_pc_q;
        iss_imm_d    = iss_imm_q;
        iss_instr_d  = iss_instr_q;
        iss_tag_d    = iss_tag_q;
        if (issue_fire) begin
            iss_rs1_d      = h1_v;
            iss_rs2_d      = h2_v;
            iss_pc_d       = pc_q[head_q];
            iss_imm_d      = imm_q[head_q];
            iss_instr_d    = instr_q[head_q];
            iss_tag_d      = rob_tag_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d         = head_q + PTR_ONE;
        end

        // Tail is never the issuing head: equal pointers mean empty (nothing issues) or full (no dispatch).
        if (dispatch_fire) begin
            valid_d[tail_q]   = 1'b1;
            instr_d[tail_q]   = dispatch_instr;
            pc_d[tail_q]      = dispatch_pc;
            imm_d[tail_q]     = dispatch_imm;
            rob_tag_d[tail_q] = dispatch_rob_tag;
            rs1_tag_d[tail_q] = dispatch_rs1_tag;
            rs2_tag_d[tail_q] = dispatch_rs2_tag;
            rs1_rdy_d[tail_q] = dispatch_rs1_ready;
            rs1_v_d[tail_q]   = dispatch_rs1_v;
            rs2_rdy_d[tail_q] = dispatch_rs2_ready;
            rs2_v_d[tail_q]   = dispatch_rs2_v;
            if (!dispatch_rs1_ready && cdb_valid_in && dispatch_rs1_tag == cdb_tag_in) begin
                rs1_rdy_d[tail_q] = 1'b1;
                rs1_v_d[tail_q]   = cdb_data_in;
            end
            if (!dispatch_rs2_ready && cdb_valid_in && dispatch_rs2_tag == cdb_tag_in) begin
                rs2_rdy_d[tail_q] = 1'b1;
                rs2_v_d[tail_q]   = cdb_data_in;
            end
            tail_d = tail_q + PTR_ONE;
        end

        unique case ({dispatch_fire, issue_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            rs1_rdy_q    <= '0;
            rs2_rdy_q    <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            comp_issue_q <= 1'b0;
            iss_rs1_q    <= '0;
            iss_rs2_q    <= '0;
            iss_pc_q     <= '0;
            iss_imm_q    <= '0;
            iss_instr_q  <= '0;
            iss_tag_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            rs1_rdy_q    <= rs1_rdy_d;
            rs2_rdy_q    <= rs2_rdy_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            comp_issue_q <= comp_issue_d;
            iss_rs1_q    <= iss_rs1_d;
            iss_rs2_q    <= iss_rs2_d;
            iss_pc_q     <= iss_pc_d;
            iss_imm_q    <= iss_imm_d;
            iss_instr_q  <= iss_instr_d;
            iss_tag_q    <= iss_tag_d;
        end
    end

    // Payload storage is qualified by valid bits and needs no reset.
    always_ff @(posedge clk) begin
        instr_q   <= instr_d;
        pc_q      <= pc_d;
        imm_q     <= imm_d;
        rob_tag_q <= rob_tag_d;
        rs1_v_q   <= rs1_v_d;
        rs2_v_q   <= rs2_v_d;
        rs1_tag_q <= rs1_tag_d;
        rs2_tag_q <= rs2_tag_d;
    end

    assign comp_issue = comp_issue_q;
    assign rs1_v      = iss_rs1_q;
    assign rs2_v      = iss_rs2_q;
    assign pc         = iss_pc_q;
    assign imm        = iss_imm_q;
    assign instr      = iss_instr_q;
    assign branch_tag = iss_tag_q;
endmodule
